bcd_tick_counter: RTL

- Consumes the divided clock level produced by the clock-divider stage and edge-detects it in the system clock domain.
- Each detected rising edge is one count tick for a run/stop-controlled, 4-digit, up/down BCD counter.
- Output drives the seven-segment display driver and status LEDs.
- Lets the switch-selected division rate set visible count speed without using a derived clock.

---
 rtl/bcd_tick_counter_pkg.sv | 17 +
 rtl/bcd_digit.sv | 33 +++
 rtl/bcd_tick_counter.sv | 88 ++++++++
 3 files changed

// File: rtl/bcd_tick_counter_pkg.sv
// Shared types and constants for the tick-driven BCD counter.
// Holds the run/stop state encoding, digit width and the digit clamp helper.
package bcd_tick_counter_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_MAX_DIGIT = 4'd9;

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  function automatic logic [DIGIT_W-1:0] clamp_digit(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decimal digit: load with clamp, or step up/down when enabled; updates on the next clk.
// term flags the digit that carries/borrows into its neighbour for the current direction.
module bcd_digit
  import bcd_tick_counter_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up,
  input  logic               load,
  input  logic [DIGIT_W-1:0] load_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic               term
);

  // >= keeps the rollover safe even if the digit were ever out of range
  assign term = up ? (digit >= BCD_MAX_DIGIT) : (digit == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      digit <= '0;
    end else if (load) begin
      digit <= clamp_digit(load_digit);
    end else if (en) begin
      if (up) begin
        digit <= (digit >= BCD_MAX_DIGIT) ? '0 : digit + 4'd1;
      end else begin
        digit <= (digit == '0) ? BCD_MAX_DIGIT : digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_tick_counter.sv
// Run/stop up/down BCD counter ticked by rising edges of clk_div sampled as data in clk.
// bcd updates on the counted edge; tick/wrap pulse for the following cycle; no backpressure.
module bcd_tick_counter
  import bcd_tick_counter_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_div,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    up,
  input  logic                    load,
  input  logic [DIGIT_W*DIGITS-1:0] load_val,
  output logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                    tick,
  output logic                    wrap,
  output logic                    running
);

  logic              clk_div_q;
  logic              edge_det;
  logic              count_en;
  state_t            state;
  state_t            state_nxt;
  logic [DIGITS:0]   en;
  logic [DIGITS-1:0] term;

  always_ff @(posedge clk) begin
    if (rst) begin
      clk_div_q <= 1'b0;
    end else begin
      clk_div_q <= clk_div;
    end
  end

  assign edge_det = clk_div & ~clk_div_q;
  // counting looks at the state before this cycle's start/stop takes effect
  assign count_en = edge_det & (state == RUNNING) & ~load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= STOPPED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      STOPPED: if (start && !stop) state_nxt = RUNNING;
      RUNNING: if (stop) state_nxt = STOPPED;
      default: state_nxt = STOPPED;
    endcase
  end

  assign running = (state == RUNNING);

  assign en[0] = count_en;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_digit u_digit (
      .clk        (clk),
      .rst        (rst),
      .en         (en[i]),
      .up         (up),
      .load       (load),
      .load_digit (load_val[i*DIGIT_W +: DIGIT_W]),
      .digit      (bcd[i*DIGIT_W +: DIGIT_W]),
      .term       (term[i])
    );
    assign en[i+1] = en[i] & term[i];
  end

  // carry out of the top digit is exactly the all-9s/all-0s rollover
  always_ff @(posedge clk) begin
    if (rst) begin
      tick <= 1'b0;
      wrap <= 1'b0;
    end else begin
      tick <= count_en;
      wrap <= en[DIGITS];
    end
  end

endmodule
